// File: rtl/anim_pkg.sv
// Shared types for the fighter animation sequencer.
// Holds the state/frame enums, default hitbox size and the frame lookup.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    PUNCH
  } state_e;

  typedef enum logic [2:0] {
    FR_STAND  = 3'd0,
    FR_WALK1  = 3'd1,
    FR_WALK2  = 3'd2,
    FR_PUNCH1 = 3'd3,
    FR_PUNCH2 = 3'd4,
    FR_PUNCH3 = 3'd5
  } frame_e;

  localparam int DEF_BOX_W = 80;
  localparam int DEF_BOX_H = 160;

  function automatic frame_e frame_of(
    input state_e     s,
    input logic [1:0] step
  );
    frame_e f;
    f = FR_STAND;
    unique case (1'b1)
      (s == WALK):  f = frame_e'(3'(FR_WALK1) + {1'b0, step});
      (s == PUNCH): f = frame_e'(3'(FR_PUNCH1) + {1'b0, step});
      default:      f = FR_STAND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fighter_anim_seq_hitbox_map.sv
// Raster-to-hitbox mapping: registered in-box test and local coords.
// One cycle of latency from draw position to outputs.
module hitbox_map
  import anim_pkg::*;
#(
  parameter int BOX_W = DEF_BOX_W,
  parameter int BOX_H = DEF_BOX_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_draw_x,
  input  logic [9:0] i_draw_y,
  input  logic [9:0] i_box_x,
  input  logic [9:0] i_box_y,
  output logic       o_in_box,
  output logic [6:0] o_local_x,
  output logic [7:0] o_local_y
);

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_in;

  logic        r_in;
  logic [6:0]  r_lx;
  logic [7:0]  r_ly;

  assign w_dx = {1'b0, i_draw_x} - {1'b0, i_box_x};
  assign w_dy = {1'b0, i_draw_y} - {1'b0, i_box_y};

  // Sign bit clear means dx >= 0, so the low bits compare unsigned.
  assign w_in_x = !w_dx[10] && (w_dx[9:0] < 10'(BOX_W));
  assign w_in_y = !w_dy[10] && (w_dy[9:0] < 10'(BOX_H));
  assign w_in   = w_in_x && w_in_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in <= 1'b0;
      r_lx <= '0;
      r_ly <= '0;
    end else begin
      r_in <= w_in;
      r_lx <= w_in ? w_dx[6:0] : 7'd0;
      r_ly <= w_in ? w_dy[7:0] : 8'd0;
    end
  end

  assign o_in_box  = r_in;
  assign o_local_x = r_lx;
  assign o_local_y = r_ly;

endmodule

// File: rtl/fighter_anim_seq.sv
// Per-fighter animation sequencer feeding the sprite render stage.
// State only moves on frame_start so a displayed frame never tears.
module fighter_anim_seq
  import anim_pkg::*;
#(
  parameter int HOLD_FRAMES = 8,
  parameter int BOX_W       = DEF_BOX_W,
  parameter int BOX_H       = DEF_BOX_H,
  parameter int WALK_LEN    = 2,
  parameter int PUNCH_LEN   = 3
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       punch,
  input  logic [9:0] fighter_x,
  input  logic [9:0] fighter_y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [2:0] anim_frame,
  output logic       mirror,
  output logic       in_box,
  output logic [6:0] local_x,
  output logic [7:0] local_y,
  output logic       busy
);

  localparam logic [3:0] HOLD_M1 = 4'(HOLD_FRAMES - 1);
  localparam logic [1:0] WALK_M1 = 2'(WALK_LEN - 1);
  localparam logic [1:0] PNCH_M1 = 2'(PUNCH_LEN - 1);

  state_e     r_state;
  logic [3:0] r_hold;
  logic [1:0] r_step;
  logic       r_mirror;
  logic       r_armed;
  frame_e     r_frame;
  logic       r_busy;

  state_e     w_nxt_state;
  logic [3:0] w_nxt_hold;
  logic [1:0] w_nxt_step;
  logic       w_nxt_mirror;
  logic       w_fs;
  logic       w_one;
  logic       w_last;

  // A pulse on the edge that releases reset is not trusted.
  assign w_fs   = frame_start && r_armed;
  assign w_one  = move_left ^ move_right;
  assign w_last = (r_hold == HOLD_M1);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_hold   = r_hold;
    w_nxt_step   = r_step;
    w_nxt_mirror = r_mirror;
    if (w_fs) begin
      unique case (r_state)
        IDLE: begin
          if (punch)      w_nxt_state = PUNCH;
          else if (w_one) w_nxt_state = WALK;
        end
        WALK: begin
          if (punch)       w_nxt_state = PUNCH;
          else if (!w_one) w_nxt_state = IDLE;
        end
        PUNCH: begin
          if (w_last && r_step == PNCH_M1)
            w_nxt_state = IDLE;
        end
        default: w_nxt_state = IDLE;
      endcase

      if (r_state != PUNCH && w_one)
        w_nxt_mirror = move_left;

      if (w_nxt_state != r_state) begin
        w_nxt_hold = '0;
        w_nxt_step = '0;
      end else if (w_last) begin
        w_nxt_hold = '0;
        if (r_state == WALK)
          w_nxt_step = (r_step == WALK_M1) ? 2'd0 : r_step + 2'd1;
        else if (r_state == PUNCH)
          w_nxt_step = r_step + 2'd1;
      end else begin
        w_nxt_hold = r_hold + 4'd1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_hold   <= '0;
      r_step   <= '0;
      r_mirror <= 1'b0;
      r_armed  <= 1'b0;
      r_frame  <= FR_STAND;
      r_busy   <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      r_state  <= w_nxt_state;
      r_hold   <= w_nxt_hold;
      r_step   <= w_nxt_step;
      r_mirror <= w_nxt_mirror;
      r_frame  <= frame_of(w_nxt_state, w_nxt_step);
      r_busy   <= (w_nxt_state == PUNCH);
    end
  end

  assign anim_frame = r_frame;
  assign mirror     = r_mirror;
  assign busy       = r_busy;

  hitbox_map #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H)
  ) u_hitbox (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .i_draw_x  (DrawX),
    .i_draw_y  (DrawY),
    .i_box_x   (fighter_x),
    .i_box_y   (fighter_y),
    .o_in_box  (in_box),
    .o_local_x (local_x),
    .o_local_y (local_y)
  );

endmodule

// File: tb/tb_fighter_anim_seq.sv
// Bench for fighter_anim_seq: vector table, directed sequences,
// and random stimulus against a frame-count reference model.
module tb_fighter_anim_seq;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       frame_start;
  logic       move_left;
  logic       move_right;
  logic       punch;
  logic [9:0] fighter_x;
  logic [9:0] fighter_y;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [2:0] anim_frame;
  logic       mirror;
  logic       in_box;
  logic [6:0] local_x;
  logic [7:0] local_y;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // model: mode 0=stand 1=walk 2=punch, ticks = frame_starts since entry
  int m_mode;
  int m_ticks;
  int m_mir;

  always #5 vga_clk = ~vga_clk;

  fighter_anim_seq dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .move_left   (move_left),
    .move_right  (move_right),
    .punch       (punch),
    .fighter_x   (fighter_x),
    .fighter_y   (fighter_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .anim_frame  (anim_frame),
    .mirror      (mirror),
    .in_box      (in_box),
    .local_x     (local_x),
    .local_y     (local_y),
    .busy        (busy)
  );

  typedef struct {
    logic [9:0] fx;
    logic [9:0] fy;
    logic [9:0] dx;
    logic [9:0] dy;
    logic       ib;
    logic [6:0] lx;
    logic [7:0] ly;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  function automatic int model_frame();
    if (m_mode == 1) return 1 + (m_ticks / 8) % 2;
    if (m_mode == 2) return 3 + m_ticks / 8;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_ticks = 0;
    m_mir   = 0;
  endtask

  task automatic model_fs(input bit l, input bit r, input bit p);
    bit one;
    int nm;
    one = l ^ r;
    nm  = m_mode;
    if (m_mode == 2)
      nm = (m_ticks + 1 >= 24) ? 0 : 2;
    else if (p)
      nm = 2;
    else
      nm = one ? 1 : 0;
    if (m_mode != 2 && one) m_mir = l;
    if (nm != m_mode) m_ticks = 0;
    else m_ticks++;
    m_mode = nm;
  endtask

  // one frame_start pulse followed by one idle cycle
  task automatic frame(input bit l, input bit r, input bit p);
    move_left   = l;
    move_right  = r;
    punch       = p;
    frame_start = 1'b1;
    tick();
    model_fs(l, r, p);
    frame_start = 1'b0;
    tick();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_frame"}, 32'(anim_frame), 32'(model_frame()));
    chk({tag, "_mirror"}, 32'(mirror), 32'(m_mir));
    chk({tag, "_busy"}, 32'(busy), 32'(m_mode == 2));
  endtask

  initial begin
    bit fs_prev;
    int ex, ey;
    bit ib;

    vt[0] = '{10'd600, 10'd100, 10'd639, 10'd259, 1'b1, 7'd39, 8'd159};
    vt[1] = '{10'd600, 10'd100, 10'd639, 10'd260, 1'b0, 7'd0,  8'd0};
    vt[2] = '{10'd10,  10'd0,   10'd5,   10'd0,   1'b0, 7'd0,  8'd0};
    vt[3] = '{10'd10,  10'd0,   10'd10,  10'd0,   1'b1, 7'd0,  8'd0};
    vt[4] = '{10'd10,  10'd20,  10'd89,  10'd179, 1'b1, 7'd79, 8'd159};
    vt[5] = '{10'd10,  10'd20,  10'd90,  10'd20,  1'b0, 7'd0,  8'd0};
    vt[6] = '{10'd0,   10'd0,   10'd0,   10'd0,   1'b1, 7'd0,  8'd0};
    vt[7] = '{10'd10,  10'd20,  10'd10,  10'd19,  1'b0, 7'd0,  8'd0};
    vt[8] = '{10'd600, 10'd100, 10'd700, 10'd150, 1'b0, 7'd0,  8'd0};
    vt[9] = '{10'd1023,10'd1023,10'd0,   10'd0,   1'b0, 7'd0,  8'd0};

    reset_n     = 1'b0;
    frame_start = 1'b0;
    move_left   = 1'b0;
    move_right  = 1'b0;
    punch       = 1'b0;
    fighter_x   = 10'd0;
    fighter_y   = 10'd0;
    DrawX       = 10'd0;
    DrawY       = 10'd0;
    model_reset();
    tick();
    tick();
    chk("rst_frame", 32'(anim_frame), 0);
    chk("rst_mirror", 32'(mirror), 0);
    chk("rst_in_box", 32'(in_box), 0);
    chk("rst_local_x", 32'(local_x), 0);
    chk("rst_local_y", 32'(local_y), 0);
    chk("rst_busy", 32'(busy), 0);

    // pulse on the reset-release edge is ignored
    fighter_x   = 10'd500;
    fighter_y   = 10'd400;
    reset_n     = 1'b1;
    frame_start = 1'b1;
    move_right  = 1'b1;
    tick();
    frame_start = 1'b0;
    move_right  = 1'b0;
    tick();
    chk("rel_frame", 32'(anim_frame), 0);
    chk("rel_busy", 32'(busy), 0);

    // walk right: 8 frames of WALK1, 8 of WALK2
    for (int i = 0; i < 16; i++) begin
      frame(1'b0, 1'b1, 1'b0);
      chk("walk_frame", 32'(anim_frame), (i < 8) ? 1 : 2);
      chk("walk_mirror", 32'(mirror), 0);
    end
    frame(1'b1, 1'b0, 1'b0);
    chk("turn_mirror", 32'(mirror), 1);
    chk("turn_frame", 32'(anim_frame), 1);

    // punch from WALK, second punch and right turn ignored
    frame(1'b0, 1'b0, 1'b1);
    chk("pun_frame0", 32'(anim_frame), 3);
    chk("pun_busy0", 32'(busy), 1);
    for (int k = 1; k < 24; k++) begin
      frame(1'b0, 1'b1, k == 10);
      chk("pun_frame", 32'(anim_frame), 3 + k / 8);
      chk("pun_busy", 32'(busy), 1);
      chk("pun_mirror", 32'(mirror), 1);
    end
    frame(1'b0, 1'b0, 1'b1);
    chk("pun_end_frame", 32'(anim_frame), 0);
    chk("pun_end_busy", 32'(busy), 0);

    // both directions: stay idle, keep facing
    frame(1'b1, 1'b1, 1'b0);
    chk("both_frame", 32'(anim_frame), 0);
    chk("both_mirror", 32'(mirror), 1);

    // reset mid-walk
    frame(1'b0, 1'b1, 1'b0);
    chk("pre_rst_frame", 32'(anim_frame), 1);
    fighter_x = 10'd0;
    fighter_y = 10'd0;
    DrawX     = 10'd5;
    DrawY     = 10'd5;
    tick();
    chk("pre_rst_in_box", 32'(in_box), 1);
    @(posedge vga_clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_frame", 32'(anim_frame), 0);
    chk("mid_rst_mirror", 32'(mirror), 0);
    chk("mid_rst_in_box", 32'(in_box), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(posedge vga_clk);
    #1;
    reset_n    = 1'b1;
    move_right = 1'b0;
    model_reset();
    tick();
    frame(1'b0, 1'b0, 1'b0);
    chk("post_rst_frame", 32'(anim_frame), 0);
    chk_model("post_rst");

    // hitbox table
    for (int i = 0; i < 10; i++) begin
      fighter_x = vt[i].fx;
      fighter_y = vt[i].fy;
      DrawX     = vt[i].dx;
      DrawY     = vt[i].dy;
      tick();
      chk($sformatf("box%0d_in", i), 32'(in_box), 32'(vt[i].ib));
      chk($sformatf("box%0d_lx", i), 32'(local_x), 32'(vt[i].lx));
      chk($sformatf("box%0d_ly", i), 32'(local_y), 32'(vt[i].ly));
    end

    // random stimulus against the model
    fs_prev = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      move_left   = ($urandom_range(0, 2) == 0);
      move_right  = ($urandom_range(0, 1) == 0);
      punch       = ($urandom_range(0, 15) == 0);
      frame_start = !fs_prev && ($urandom_range(0, 2) == 0);
      fighter_x   = 10'($urandom_range(0, 1023));
      fighter_y   = 10'($urandom_range(0, 1023));
      DrawX       = 10'(int'(fighter_x) + $urandom_range(0, 99) - 10);
      DrawY       = 10'(int'(fighter_y) + $urandom_range(0, 179) - 10);
      ex = int'(DrawX) - int'(fighter_x);
      ey = int'(DrawY) - int'(fighter_y);
      ib = (ex >= 0) && (ex < 80) && (ey >= 0) && (ey < 160);
      if (frame_start) model_fs(move_left, move_right, punch);
      fs_prev = frame_start;
      tick();
      chk_model("rnd");
      chk("rnd_in_box", 32'(in_box), 32'(ib));
      chk("rnd_local_x", 32'(local_x), ib ? ex : 0);
      chk("rnd_local_y", 32'(local_y), ib ? ey : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
